aes_round_iter: RTL and testbench
=================================

# aes_round_iter

Iterative AES encryption core, generalising the single pipelined round into a complete cipher datapath. It applies the initial AddRoundKey, NR−1 full rounds and one final round (no MixColumns) through a single round datapath, one round per clock. A valid/ready handshake sits on each side, and round keys are read from an external key-schedule store via an index port. NR selects AES-128/192/256.

## Interface
- NR, default 10: number of rounds; legal values 10, 12, 14; any other value is a elaboration error.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  plaintext block offered.
- in_ready  out  1  core can accept a block; high only in IDLE.
- in_data  in  128  plaintext; byte 0 (FIPS-197 s[0,0]) at [127:120], column-major.
- rk_idx  out  4  round-key index requested this cycle, 0..NR.
- rk  in  128  round key rk_idx; combinational read, same-cycle valid.
- out_valid  out  1  ciphertext available.
- out_ready  in  1  consumer accepts ciphertext.
- out_data  out  128  ciphertext, same byte order as in_data.
- busy  out  1  high in ROUND or DONE.

## Operation
- FSM states: IDLE, ROUND, DONE.
- IDLE: in_ready=1, rk_idx=0. On in_valid: state ← in_data ^ rk, rnd ← 1, go to ROUND.
- ROUND: rk_idx=rnd. Each cycle: state ← round(state, rk, final=(rnd==NR)), rnd ← rnd+1.
  - Full round = SubBytes → ShiftRows → MixColumns → AddRoundKey.
  - Final round omits MixColumns.
  - When rnd==NR, go to DONE.
- DONE: out_valid=1, out_data=state, held stable until out_ready. On out_ready, go to IDLE.
- No same-cycle turnaround: a new block is accepted no earlier than the cycle after the output handshake.
- in_data and rk are sampled only on the edges described above; changes at other times are ignored.
- rnd is a 4-bit counter. It never wraps: its maximum is NR ≤ 14.
- In DONE, rk_idx=NR (don't-care for consumers).
- GF(2^8) arithmetic: xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1b : 8'h00).

## Timing
- Reset (asynchronous, rst=0):
  - state=IDLE, rnd=0, state register=0.
  - in_ready=1, out_valid=0, out_data=0, busy=0, rk_idx=0.
- Reset mid-operation aborts the block with no output; the core is accepting on the first edge after rst releases.
- Latency: input accepted at edge E0 → out_valid high after edge E0+NR.
- Throughput: one block per NR+2 cycles with out_ready held high.
- Output backpressure holds out_data and out_valid indefinitely; in_ready stays 0 throughout.
- All outputs are registered or decoded from state alone, except rk_idx, which is combinational from FSM and rnd (no input-to-output path).

## Configuration
- AES_ROUND_ZEROIZE_EN defined:
  - The state register clears to 0 on the out_valid && out_ready edge.
  - out_data is forced to 0 whenever out_valid=0.
- AES_ROUND_ZEROIZE_EN undefined:
  - The state register retains the last ciphertext after handshake.
  - out_data shows the raw state register at all times.
- Cycle timing is identical in both builds.

## Structure
- Shared package aes_pkg holds:
  - the S-box function (256-entry case);
  - the xtime function;
  - the legal NR constants (AES128_NR=10, AES192_NR=12, AES256_NR=14);
  - the FSM state typedef.
- One sub-module, aes_round_comb: purely combinational; inputs state, key, final; output next state.
- aes_round_iter contains only the FSM, the counter and the registers.

## Test plan
- NR=10, key 2b7e1516…09cf4f3c, in_data 3243f6a8885a308d313198a2e0370734 → out_data 3925841d02dc09fbdc118597196a0b32, out_valid after exactly 10 cycles.
- NR=10/12/14, FIPS-197 C.1/C.2/C.3 with plaintext 00112233…eeff → 69c4e0d86a7b0430d8cdb78070b4c55a / dda97ca4864cdfe06eaf70a0ec0d7191 / 8ea2b7ca516745bfeafc49904b496089.
- Hold out_ready=0 for 20 cycles after DONE → out_data stable, in_ready=0, in_valid ignored; release → IDLE next cycle.
- Drive rst=0 while rnd=5 → outputs at reset values immediately; next block after release produces correct ciphertext.
- Back-to-back blocks with in_valid and out_ready held high → one result every NR+2 cycles; rk_idx sequence 0,1..NR per block.
- AES_ROUND_ZEROIZE_EN build → out_data=0 outside out_valid, state register 0 after handshake; non-ZEROIZE build keeps the ciphertext.

Source files
------------

// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES definitions for the iterative encryption core.
//   - AES128_NR / AES192_NR / AES256_NR : legal round counts
//   - aes_fsm_e                         : round-controller state encoding
//   - xtime()                           : multiply-by-x in GF(2^8)
//   - sbox()                            : forward AES S-box (256-entry case)
// No ports; imported with "import aes_pkg::*;".
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam int AES128_NR = 10;
  localparam int AES192_NR = 12;
  localparam int AES256_NR = 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } aes_fsm_e;

  // Multiply by x modulo the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] s;
    s = 8'h00;
    case (b)
      8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
      8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
      8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
      8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
      8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
      8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
      8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
      8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
      8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
      8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
      8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
      8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
      8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
      8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
      8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
      8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
      8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
      8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
      8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
      8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
      8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
      8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
      8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
      8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
      8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
      8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
      8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
      8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
      8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
      8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
      8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
      8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/aes_round_comb.sv
// ---------------------------------------------------------------------------
// aes_round_comb
// One AES encryption round, purely combinational:
//   SubBytes -> ShiftRows -> MixColumns (skipped when is_final) -> AddRoundKey
// Ports:
//   state      in  128  current cipher state, byte 0 (s[0,0]) at [127:120],
//                       column-major (byte index = row + 4*column)
//   key        in  128  round key, same byte order
//   is_final   in  1    final round: MixColumns is bypassed
//   next_state out 128  state after the round
// ---------------------------------------------------------------------------
module aes_round_comb
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] key,
  input  logic         is_final,
  output logic [127:0] next_state
);

  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_sub_shift
      assign sb[gi] = sbox(state[127-8*gi -: 8]);
      // Row r = gi%4 rotates left by r columns: s'[r,c] = s[r,(c+r)%4].
      assign sr[gi] = sb[(gi % 4) + 4 * (((gi / 4) + (gi % 4)) % 4)];
    end

    for (gi = 0; gi < 4; gi++) begin : g_mix
      logic [7:0] a0, a1, a2, a3;
      assign a0 = sr[4*gi];
      assign a1 = sr[4*gi+1];
      assign a2 = sr[4*gi+2];
      assign a3 = sr[4*gi+3];
      // 3*a is expressed as xtime(a) ^ a.
      assign mc[4*gi]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      assign mc[4*gi+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      assign mc[4*gi+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      assign mc[4*gi+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end

    for (gi = 0; gi < 16; gi++) begin : g_add_key
      assign next_state[127-8*gi -: 8] = (is_final ? sr[gi] : mc[gi]) ^ key[127-8*gi -: 8];
    end
  endgenerate

endmodule

// File: rtl/aes_round_iter.sv
// ---------------------------------------------------------------------------
// aes_round_iter
// Iterative AES encryption core: initial AddRoundKey on accept, then NR rounds
// (the last without MixColumns) through one shared round datapath, one round
// per clock. Round keys come from an external store addressed by rk_idx.
// Parameter:
//   NR         10 / 12 / 14 for AES-128 / 192 / 256 (others fail elaboration)
// Ports:
//   clk        in  1    rising-edge clock
//   rst        in  1    asynchronous reset, active low
//   in_valid   in  1    plaintext offered
//   in_ready   out 1    core idle and able to accept
//   in_data    in  128  plaintext, byte 0 at [127:120], column-major
//   rk_idx     out 4    round-key index requested this cycle
//   rk         in  128  round key at rk_idx (same-cycle combinational read)
//   out_valid  out 1    ciphertext available
//   out_ready  in  1    consumer accepts ciphertext
//   out_data   out 128  ciphertext
//   busy       out 1    block in flight or awaiting output handshake
// Build option:
//   AES_ROUND_ZEROIZE_EN  clear the state register on the output handshake
//                         and force out_data to 0 while out_valid is low.
// ---------------------------------------------------------------------------
module aes_round_iter
  import aes_pkg::*;
#(
  parameter int NR = AES128_NR
)
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  generate
    if (NR != AES128_NR && NR != AES192_NR && NR != AES256_NR) begin : g_bad_nr
      $error("aes_round_iter: NR must be 10, 12 or 14");
    end
  endgenerate

  localparam logic [3:0] LAST_RND = 4'(NR);

  aes_fsm_e     fsm_reg;
  logic [3:0]   rnd_reg;
  logic [127:0] data_reg;
  logic [127:0] round_out;
  logic         last_rnd;

  assign last_rnd = (rnd_reg == LAST_RND);

  aes_round_comb u_round (
    .state      (data_reg),
    .key        (rk),
    .is_final   (last_rnd),
    .next_state (round_out)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_reg  <= ST_IDLE;
      rnd_reg  <= 4'd0;
      data_reg <= '0;
    end else begin
      case (fsm_reg)
        ST_IDLE: begin
          if (in_valid) begin
            data_reg <= in_data ^ rk;
            rnd_reg  <= 4'd1;
            fsm_reg  <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          data_reg <= round_out;
          // rnd stops at NR so rk_idx reads NR while DONE and never wraps.
          if (last_rnd) begin
            fsm_reg <= ST_DONE;
          end else begin
            rnd_reg <= rnd_reg + 4'd1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            fsm_reg <= ST_IDLE;
            rnd_reg <= 4'd0;
`ifdef AES_ROUND_ZEROIZE_EN
            data_reg <= '0;
`endif
          end
        end
        default: begin
          fsm_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (fsm_reg == ST_IDLE);
  assign out_valid = (fsm_reg == ST_DONE);
  assign busy      = (fsm_reg != ST_IDLE);
  assign rk_idx    = (fsm_reg == ST_IDLE) ? 4'd0 : rnd_reg;

`ifdef AES_ROUND_ZEROIZE_EN
  assign out_data = out_valid ? data_reg : '0;
`else
  assign out_data = data_reg;
`endif

endmodule

// File: tb/tb_aes_round_iter.sv
// ---------------------------------------------------------------------------
// tb_aes_round_iter
// Three cores (NR = 10, 12, 14) fed from bench-side key stores. Stimulus
// pushes the known-answer ciphertext into a scoreboard queue; a monitor pops
// and compares on every output handshake and checks accept-to-valid latency.
// ---------------------------------------------------------------------------
module tb_aes_round_iter;
  import aes_pkg::*;

  localparam logic [127:0] PT_B     = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B     = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_C192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT_C256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KEY_B    = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY_C128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY_C192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] KEY_C256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] in_data   [3];
  logic [3:0]   rk_idx    [3];
  logic [127:0] rk        [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] out_data  [3];
  logic         busy      [3];
  logic [127:0] rkey      [3][16];

  typedef struct {
    int           id;
    logic [127:0] ct;
  } exp_t;
  exp_t exp_q[$];

  int cyc = 0;
  int n_cmp = 0;
  int n_mis = 0;
  int acc_cyc [3];

  always @(posedge clk) cyc <= cyc + 1;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      aes_round_iter #(.NR(10 + 2*gi)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid[gi]),
        .in_ready  (in_ready[gi]),
        .in_data   (in_data[gi]),
        .rk_idx    (rk_idx[gi]),
        .rk        (rk[gi]),
        .out_valid (out_valid[gi]),
        .out_ready (out_ready[gi]),
        .out_data  (out_data[gi]),
        .busy      (busy[gi])
      );
      assign rk[gi] = rkey[gi][rk_idx[gi]];
    end
  endgenerate

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // FIPS-197 key expansion into the round-key store of instance g.
  task automatic expand_key(input int g, input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subword(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) rkey[g][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    for (int r = nr + 1; r < 16; r++) rkey[g][r] = '0;
  endtask

  task automatic chk_reset(input int i);
    chk($sformatf("rst_in_ready[%0d]", i), 128'(in_ready[i]), 128'd1);
    chk($sformatf("rst_out_valid[%0d]", i), 128'(out_valid[i]), 128'd0);
    chk($sformatf("rst_out_data[%0d]", i), out_data[i], 128'd0);
    chk($sformatf("rst_busy[%0d]", i), 128'(busy[i]), 128'd0);
    chk($sformatf("rst_rk_idx[%0d]", i), 128'(rk_idx[i]), 128'd0);
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send_block(input int g, input logic [127:0] pt, input logic [127:0] ct,
                            input bit keep, output int acc);
    int waited;
    waited = 0;
    acc = -1;
    in_valid[g] = 1'b1;
    in_data[g]  = pt;
    while (!in_ready[g] && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready[g]) begin
      n_cmp++;
      n_mis++;
      $display("FAIL send_timeout[%0d]: in_ready=%0b required 1", g, in_ready[g]);
      in_valid[g] = 1'b0;
    end else begin
      chk($sformatf("rk_idx_idle[%0d]", g), 128'(rk_idx[g]), 128'd0);
      exp_q.push_back('{id: g, ct: ct});
      $display("in[%0d]  pt=%h", g, pt);
      @(posedge clk); #1;
      acc         = cyc;
      acc_cyc[g]  = cyc;
      in_valid[g] = keep;
      in_data[g]  = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  task automatic drop_expected(input int g);
    int idx;
    idx = -1;
    for (int k = 0; k < exp_q.size() && idx < 0; k++) if (exp_q[k].id == g) idx = k;
    if (idx >= 0) exp_q.delete(idx);
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL drain_timeout: %0d outputs outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Output monitor: compares on each handshake, checks latency on each rise.
  initial begin
    logic prev_valid [3];
    int   idx;
    for (int i = 0; i < 3; i++) prev_valid[i] = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (rst && out_valid[i] && !prev_valid[i])
          chk($sformatf("latency[%0d]", i), 128'(cyc - acc_cyc[i]), 128'(10 + 2*i));
        if (rst && out_valid[i] && out_ready[i]) begin
          idx = -1;
          for (int k = 0; k < exp_q.size() && idx < 0; k++) if (exp_q[k].id == i) idx = k;
          if (idx < 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL unexpected_output[%0d]: got %h required no output", i, out_data[i]);
          end else begin
            $display("out[%0d] ct=%h expected=%h", i, out_data[i], exp_q[idx].ct);
            chk($sformatf("ciphertext[%0d]", i), out_data[i], exp_q[idx].ct);
            exp_q.delete(idx);
          end
        end
        prev_valid[i] = rst ? out_valid[i] : 1'b0;
      end
    end
  end

  initial begin
    int a;
    int prev;
    int rel;
    int waited;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      in_data[i]   = '0;
      out_ready[i] = 1'b1;
      acc_cyc[i]   = 0;
    end
    expand_key(0, KEY_B, 4);
    expand_key(1, KEY_C192, 6);
    expand_key(2, KEY_C256, 8);
    #1 rst = 1'b0;
    #11;
    for (int i = 0; i < 3; i++) chk_reset(i);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Known-answer vectors.
    send_block(0, PT_B, CT_B, 1'b0, a);
    drain();
    expand_key(0, KEY_C128, 4);
    send_block(0, PT_C, CT_C128, 1'b0, a);
    drain();
    send_block(1, PT_C, CT_C192, 1'b0, a);
    send_block(2, PT_C, CT_C256, 1'b0, a);
    drain();

    // Output backpressure for 20 cycles with in_valid asserted.
    out_ready[0] = 1'b0;
    send_block(0, PT_C, CT_C128, 1'b0, a);
    waited = 0;
    while (!out_valid[0] && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("bp_reached_done", 128'(out_valid[0]), 128'd1);
    for (int j = 0; j < 20; j++) begin
      chk("bp_out_data", out_data[0], CT_C128);
      chk("bp_out_valid", 128'(out_valid[0]), 128'd1);
      chk("bp_in_ready", 128'(in_ready[0]), 128'd0);
      in_valid[0] = 1'b1;
      in_data[0]  = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready", 128'(in_ready[0]), 128'd1);
    chk("release_out_valid", 128'(out_valid[0]), 128'd0);
    chk("release_busy", 128'(busy[0]), 128'd0);
`ifdef AES_ROUND_ZEROIZE_EN
    chk("post_hs_out_data", out_data[0], 128'd0);
`else
    chk("post_hs_out_data", out_data[0], CT_C128);
`endif
    drain();

    // Back-to-back blocks: one result every NR+2 cycles, rk_idx 0,1..NR.
    prev = 0;
    for (int t = 0; t < 3; t++) begin
      send_block(0, PT_C, CT_C128, (t < 2), a);
      if (t > 0) chk("b2b_period", 128'(a - prev), 128'd12);
      prev = a;
      for (int j = 1; j <= 10; j++) begin
        chk($sformatf("rk_idx_round%0d", j), 128'(rk_idx[0]), 128'(j));
`ifdef AES_ROUND_ZEROIZE_EN
        if (j == 1) chk("zeroize_out_data_busy", out_data[0], 128'd0);
`endif
        @(posedge clk); #1;
      end
      chk("rk_idx_done", 128'(rk_idx[0]), 128'd10);
      chk("b2b_out_valid", 128'(out_valid[0]), 128'd1);
    end
    drain();

    // Reset while rnd = 5: immediate reset values, no output, then a clean block.
    send_block(0, PT_C, CT_C128, 1'b0, a);
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("rk_idx_before_rst", 128'(rk_idx[0]), 128'd5);
    rst = 1'b0;
    #1;
    chk_reset(0);
    drop_expected(0);
    #2;
    rst = 1'b1;
    rel = cyc;
    send_block(0, PT_C, CT_C128, 1'b0, a);
    chk("first_edge_accept", 128'(a - rel), 128'd1);
    drain();

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #100000;
    n_mis++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $fatal(1, "watchdog");
  end

endmodule
